// File: rtl/alu_exec_unit.sv
// Execute stage: instruction register, field decode, combinational ALU and NZCV flags register.
// Latency: result/reg_write are combinational from the latched instruction; flags update on the next clk.
// Backpressure: none; a new instruction is latched every cycle.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   pc_count        - program counter, forwarded zero-extended as ram_pc_address
//   instruction_in  - fetched instruction word, latched into instruction_out each clk
//   in1, in2        - register-bank operands for src1/src2
//   src1_addr, src2_addr, dest - register addresses decoded from instruction_out
//   result, reg_write - ALU result and write enable for dest
//   flags           - registered {N,Z,C,V}
module alu_exec_unit #(
   parameter logic [31:0] NOP_INSTR = 32'hEF00_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  pc_count,
   input  logic [31:0] instruction_in,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] ram_pc_address,
   output logic [31:0] instruction_out,
   output logic [3:0]  src1_addr,
   output logic [3:0]  src2_addr,
   output logic [3:0]  dest,
   output logic [31:0] result,
   output logic        reg_write,
   output logic [3:0]  flags
);

   logic [31:0] instr_q;
   logic [3:0]  flags_q;

   logic [3:0]  cond;
   logic [3:0]  opcode;
   logic        s_bit;
   logic [2:0]  sr;
   logic [31:0] imm;
   logic        n_f, z_f, c_f, v_f;
   logic        exec;

   logic [31:0] add_b, sub_b;
   logic [32:0] sum_w, diff_w;
   logic [4:0]  amt;
   logic [5:0]  amt_inv;
   logic [32:0] lsl_w, lsr_w, asr_w;

   logic [31:0] alu_r;
   logic        c_n, v_n;
   logic        flag_we;
   logic [3:0]  flags_nxt;

   assign ram_pc_address  = {24'b0, pc_count};
   assign instruction_out = instr_q;
   assign flags           = flags_q;

   assign cond      = instr_q[31:28];
   assign opcode    = instr_q[27:24];
   assign s_bit     = instr_q[23];
   assign dest      = instr_q[22:19];
   assign src1_addr = instr_q[18:15];
   assign src2_addr = instr_q[14:11];
   assign imm       = {16'b0, instr_q[18:3]};
   assign sr        = instr_q[2:0];

   assign {n_f, z_f, c_f, v_f} = flags_q;

   always_comb begin
      exec = 1'b0;
      case (cond)
         4'h0: exec = z_f;
         4'h1: exec = !z_f;
         4'h2: exec = c_f;
         4'h3: exec = !c_f;
         4'h4: exec = n_f;
         4'h5: exec = !n_f;
         4'h6: exec = v_f;
         4'h7: exec = !v_f;
         4'h8: exec = c_f && !z_f;
         4'h9: exec = !c_f || z_f;
         4'hA: exec = (n_f == v_f);
         4'hB: exec = (n_f != v_f);
         4'hC: exec = !z_f && (n_f == v_f);
         4'hD: exec = z_f || (n_f != v_f);
         4'hE: exec = 1'b1;
         default: exec = 1'b0;
      endcase
   end

   // Shared adder/subtractor; bit 32 is the carry (add) or borrow (sub).
   assign add_b  = (opcode == 4'h8) ? imm : in2;
   assign sub_b  = (opcode == 4'h9) ? imm : in2;
   assign sum_w  = {1'b0, in1} + {1'b0, add_b};
   assign diff_w = {1'b0, in1} - {1'b0, sub_b};

   // Shifters carry one extra bit that captures the last bit shifted out.
   assign amt     = in2[4:0];
   assign amt_inv = 6'd32 - {1'b0, amt};
   assign lsl_w   = {1'b0, in1} << amt;
   assign lsr_w   = {in1, 1'b0} >> amt;
   assign asr_w   = $signed({in1, 1'b0}) >>> amt;

   always_comb begin
      alu_r = 32'b0;
      c_n   = c_f;
      v_n   = v_f;
      case (opcode)
         4'h0, 4'h8: begin
            alu_r = sum_w[31:0];
            c_n   = sum_w[32];
            v_n   = (in1[31] == add_b[31]) && (sum_w[31] != in1[31]);
         end
         4'h1, 4'h9, 4'hB: begin
            alu_r = diff_w[31:0];
            c_n   = !diff_w[32];
            v_n   = (in1[31] != sub_b[31]) && (diff_w[31] != in1[31]);
         end
         4'h2: alu_r = in1 & in2;
         4'h3: alu_r = in1 | in2;
         4'h4: alu_r = in1 ^ in2;
         4'h5: alu_r = ~in1;
         4'h6: alu_r = in1;
         4'h7: alu_r = imm;
         4'hA: begin
            alu_r = in1;
            case (sr)
               3'b001: begin alu_r = lsl_w[31:0]; c_n = lsl_w[32]; end
               3'b010: begin alu_r = lsr_w[32:1]; c_n = lsr_w[0];  end
               3'b011: begin alu_r = asr_w[32:1]; c_n = asr_w[0];  end
               3'b100: begin
                  alu_r = (in1 >> amt) | (in1 << amt_inv);
                  c_n   = alu_r[31];
               end
               3'b101: begin
                  alu_r = (in1 << amt) | (in1 >> amt_inv);
                  c_n   = alu_r[0];
               end
               default: alu_r = in1;
            endcase
            // A zero shift moves no bit out, so carry is kept.
            if (amt == 5'd0) c_n = c_f;
         end
         4'hC, 4'hD: alu_r = in1;
         default: alu_r = 32'b0;
      endcase
   end

   assign flag_we   = exec && ((s_bit && (opcode <= 4'hA)) || (opcode == 4'hB));
   assign flags_nxt = {alu_r[31], (alu_r == 32'b0), c_n, v_n};

   assign result    = reset ? 32'b0 : alu_r;
   assign reg_write = !reset && exec && (opcode <= 4'hA);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= NOP_INSTR;
         flags_q <= 4'b0000;
      end else begin
         instr_q <= instruction_in;
         if (flag_we) flags_q <= flags_nxt;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, reset corner cases, and random
// instructions compared against a behavioural model of the execute stage.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pc_count;
   logic [31:0] instruction_in, in1, in2;
   logic [31:0] ram_pc_address, instruction_out, result;
   logic [3:0]  src1_addr, src2_addr, dest, flags;
   logic        reg_write;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] NOP = 32'hEF00_0000;

   alu_exec_unit dut (
      .clk(clk), .reset(reset), .pc_count(pc_count),
      .instruction_in(instruction_in), .in1(in1), .in2(in2),
      .ram_pc_address(ram_pc_address), .instruction_out(instruction_out),
      .src1_addr(src1_addr), .src2_addr(src2_addr), .dest(dest),
      .result(result), .reg_write(reg_write), .flags(flags)
   );

   always #5 clk = ~clk;

   // Model state: flags and the instruction currently held by the stage.
   logic [3:0]  m_flags;
   logic [31:0] p_ins, p_a, p_b;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        rw;
      logic [3:0]  fl;
   } vec_t;

   vec_t tv[17];

   function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op, input logic s,
                                      input logic [2:0] sr);
      return {c, op, s, 4'd3, 4'd1, 4'd2, 8'h00, sr};
   endfunction

   function automatic logic [31:0] mki(input logic [3:0] c, input logic [3:0] op, input logic [15:0] im);
      return {c, op, 1'b0, 4'd4, im, 3'b000};
   endfunction

   // Behavioural execute model built from the architectural rules.
   task automatic ref_step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] f, output logic [31:0] res, output logic rw,
                           output logic [3:0] fn);
      logic nf, zf, cf, vf, ex, cn, vn, upd, outb;
      logic [3:0]  op;
      logic [31:0] imm, r;
      longint unsigned ua, uo;
      longint sa, so, sres;
      int amt;
      {nf, zf, cf, vf} = f;
      op  = ins[27:24];
      imm = {16'b0, ins[18:3]};
      case (ins[31:28])
         4'h0: ex = zf;            4'h1: ex = !zf;
         4'h2: ex = cf;            4'h3: ex = !cf;
         4'h4: ex = nf;            4'h5: ex = !nf;
         4'h6: ex = vf;            4'h7: ex = !vf;
         4'h8: ex = cf && !zf;     4'h9: ex = !cf || zf;
         4'hA: ex = (nf == vf);    4'hB: ex = (nf != vf);
         4'hC: ex = !zf && (nf == vf);
         4'hD: ex = zf || (nf != vf);
         4'hE: ex = 1'b1;
         default: ex = 1'b0;
      endcase
      cn = cf; vn = vf; r = 32'b0;
      ua = a; sa = $signed(a);
      if (op == 4'h8 || op == 4'h9) begin uo = imm; so = longint'(imm); end
      else begin uo = b; so = $signed(b); end
      case (op)
         4'h0, 4'h8: begin
            r = 32'(ua + uo);
            cn = (ua + uo) >= 64'h1_0000_0000;
            sres = sa + so;
            vn = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
         end
         4'h1, 4'h9, 4'hB: begin
            r = 32'(ua - uo);
            cn = (ua >= uo);
            sres = sa - so;
            vn = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
         end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = ~a;
         4'h6: r = a;
         4'h7: r = imm;
         4'hA: begin
            r = a;
            amt = int'(b[4:0]);
            if (ins[2:0] >= 3'd1 && ins[2:0] <= 3'd5) begin
               for (int i = 0; i < amt; i++) begin
                  case (ins[2:0])
                     3'd1: begin outb = r[31]; r = {r[30:0], 1'b0}; end
                     3'd2: begin outb = r[0];  r = {1'b0, r[31:1]}; end
                     3'd3: begin outb = r[0];  r = {r[31], r[31:1]}; end
                     3'd4: begin outb = r[0];  r = {r[0], r[31:1]}; end
                     default: begin outb = r[31]; r = {r[30:0], r[31]}; end
                  endcase
                  cn = outb;
               end
            end
         end
         4'hC, 4'hD: r = a;
         default: r = 32'b0;
      endcase
      res = r;
      rw  = ex && (op <= 4'hA);
      upd = ex && ((ins[23] && op <= 4'hA) || op == 4'hB);
      fn  = upd ? {r[31], (r == 32'b0), cn, vn} : f;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one instruction: latch it at the next edge, then drive its operands and check.
   task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic        erw;
      logic [3:0]  ef;
      instruction_in = ins;
      @(posedge clk);
      ref_step(p_ins, p_a, p_b, m_flags, er, erw, ef);
      m_flags = ef;
      #1;
      in1 = a; in2 = b; pc_count = 8'($urandom);
      #1;
      ref_step(ins, a, b, m_flags, er, erw, ef);
      chk("instruction_out", instruction_out, ins);
      chk("fields", {20'b0, src1_addr, src2_addr, dest}, {20'b0, ins[18:15], ins[14:11], ins[22:19]});
      chk("result", result, er);
      chk("reg_write", {31'b0, reg_write}, {31'b0, erw});
      chk("flags", {28'b0, flags}, {28'b0, m_flags});
      chk("ram_pc_address", ram_pc_address, {24'b0, pc_count});
      p_ins = ins; p_a = a; p_b = b;
   endtask

   initial begin
      logic [31:0] ins, a, b;
      logic [3:0]  c;

      tv[0]  = '{mk(4'hE, 4'h0, 1, 0), 32'hFFFF_FFFF, 32'h1, 32'h0,         1, 4'b0000};
      tv[1]  = '{mk(4'hE, 4'h1, 1, 0), 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 4'b0110};
      tv[2]  = '{mk(4'h6, 4'h6, 0, 0), 32'h1234,      32'h0, 32'h1234,      1, 4'b0011};
      tv[3]  = '{mk(4'h7, 4'h6, 1, 0), 32'h5,         32'h0, 32'h5,         0, 4'b0011};
      tv[4]  = '{mk(4'hE, 4'hB, 0, 0), 32'h5,         32'h7, 32'hFFFF_FFFE, 0, 4'b0011};
      tv[5]  = '{mk(4'hB, 4'h6, 0, 0), 32'h9,         32'h0, 32'h9,         1, 4'b1000};
      tv[6]  = '{mk(4'hA, 4'h6, 0, 0), 32'h9,         32'h0, 32'h9,         0, 4'b1000};
      tv[7]  = '{mki(4'hE, 4'h7, 16'hBEEF), 32'h0,    32'h0, 32'h0000_BEEF, 1, 4'b1000};
      tv[8]  = '{mki(4'hE, 4'h8, 16'hFFFF), 32'h1,    32'h0, 32'h0001_0000, 1, 4'b1000};
      tv[9]  = '{mk(4'hE, 4'hA, 1, 3'b100), 32'hF,    32'h4, 32'hF000_0000, 1, 4'b1000};
      tv[10] = '{mk(4'hE, 4'hA, 1, 3'b001), 32'h1234_5678, 32'h0, 32'h1234_5678, 1, 4'b1010};
      tv[11] = '{mk(4'hE, 4'hA, 1, 3'b011), 32'h8000_0000, 32'h4, 32'hF800_0000, 1, 4'b0010};
      tv[12] = '{mk(4'hE, 4'hF, 1, 0), 32'h0,         32'h0, 32'h0,         0, 4'b1000};
      tv[13] = '{mk(4'hE, 4'hC, 1, 0), 32'h100,       32'h0, 32'h100,       0, 4'b1000};
      tv[14] = '{mk(4'hE, 4'hD, 1, 0), 32'h200,       32'h0, 32'h200,       0, 4'b1000};
      tv[15] = '{mk(4'hF, 4'h0, 1, 0), 32'h1,         32'h1, 32'h2,         0, 4'b1000};
      tv[16] = '{NOP,                  32'h0,         32'h0, 32'h0,         0, 4'b1000};

      // Reset held with a flag-setting ADD presented: outputs stay quiet.
      reset = 1'b1;
      pc_count = 8'h2A;
      instruction_in = mk(4'hE, 4'h0, 1, 0);
      in1 = 32'hFFFF_FFFF; in2 = 32'h1;
      repeat (2) @(posedge clk);
      #2;
      chk("reset instruction_out", instruction_out, NOP);
      chk("reset flags", {28'b0, flags}, 32'h0);
      chk("reset result", result, 32'h0);
      chk("reset reg_write", {31'b0, reg_write}, 32'h0);
      chk("ram_pc_address 2A", ram_pc_address, 32'h0000_002A);
      reset = 1'b0;
      #1;
      chk("post-reset instruction_out", instruction_out, NOP);
      chk("post-reset reg_write", {31'b0, reg_write}, 32'h0);
      p_ins = NOP; p_a = in1; p_b = in2; m_flags = 4'b0000;

      for (int i = 0; i < 17; i++) begin
         step(tv[i].ins, tv[i].a, tv[i].b);
         chk($sformatf("vec%0d result", i), result, tv[i].res);
         chk($sformatf("vec%0d reg_write", i), {31'b0, reg_write}, {31'b0, tv[i].rw});
         chk($sformatf("vec%0d flags", i), {28'b0, flags}, {28'b0, tv[i].fl});
      end

      // Random instructions; condition biased towards AL so flags evolve.
      for (int i = 0; i < 400; i++) begin
         c = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
         ins = {c, 4'($urandom), 24'($urandom)};
         case ($urandom_range(0, 3))
            0: a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            1: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         step(ins, a, b);
      end

      // Reset pulse between edges while an ADDS is pending: immediate effect, update dropped.
      step(mk(4'hE, 4'h0, 1, 0), 32'hFFFF_FFFF, 32'h1);
      #1;
      reset = 1'b1;
      #1;
      chk("midreset instruction_out", instruction_out, NOP);
      chk("midreset flags", {28'b0, flags}, 32'h0);
      chk("midreset result", result, 32'h0);
      chk("midreset reg_write", {31'b0, reg_write}, 32'h0);
      reset = 1'b0;
      p_ins = NOP; m_flags = 4'b0000;
      step(NOP, 32'h0, 32'h0);
      chk("midreset flags after clk", {28'b0, flags}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
